// File: rtl/l1_maint_sequencer.sv
// Cache-maintenance sequencer: orders D-cache flush/clear and I-cache clear
// requests for one maintenance op at a time, with a per-step watchdog.
module l1_maint_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       resp_valid,
    output logic       resp_err,
    output logic       busy,
    output logic       dcache_flush,
    output logic       dcache_clear,
    input  logic       dcache_flush_done,
    input  logic       dcache_clear_done,
    output logic       icache_clear,
    input  logic       icache_clear_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // A disabled watchdog still needs a legal (1-bit) counter vector.
    localparam int unsigned CW = (CNT_W == 0) ? 1 : CNT_W;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] OP_DFLUSH    = 2'b01;
    localparam logic [1:0] OP_ICLEAR    = 2'b10;
    localparam logic [1:0] OP_INVAL_ALL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DSTEP = 2'd1,
        S_ISTEP = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic            busy_q, busy_d;
    logic            dcache_flush_q, dcache_flush_d;
    logic            dcache_clear_q, dcache_clear_d;
    logic            icache_clear_q, icache_clear_d;

    logic            limit_hit;
    logic            d_done;

    // Next-state, watchdog and registered-output decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        limit_hit = WDOG_EN && (cnt_q == CNT_LIMIT);
        // Only the done matching the request actually raised is observed.
        d_done    = (op_q == OP_INVAL_ALL) ? dcache_clear_done : dcache_flush_done;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (req_op == OP_ICLEAR) ? S_ISTEP : S_DSTEP;
                end
            end
            S_DSTEP: begin
                if (d_done) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_DFLUSH) ? S_RESP : S_ISTEP;
                end else if (limit_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (WDOG_EN) begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_ISTEP: begin
                if (icache_clear_done) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (limit_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (WDOG_EN) begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d    = (state_d == S_IDLE);
        resp_valid_d   = (state_d == S_RESP);
        resp_err_d     = (state_d == S_RESP) && err_d;
        busy_d         = (state_d != S_IDLE);
        dcache_flush_d = (state_d == S_DSTEP) && (op_d != OP_INVAL_ALL);
        dcache_clear_d = (state_d == S_DSTEP) && (op_d == OP_INVAL_ALL);
        icache_clear_d = (state_d == S_ISTEP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            op_q           <= 2'b00;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            busy_q         <= 1'b0;
            dcache_flush_q <= 1'b0;
            dcache_clear_q <= 1'b0;
            icache_clear_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            busy_q         <= busy_d;
            dcache_flush_q <= dcache_flush_d;
            dcache_clear_q <= dcache_clear_d;
            icache_clear_q <= icache_clear_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign busy         = busy_q;
    assign dcache_flush = dcache_flush_q;
    assign dcache_clear = dcache_clear_q;
    assign icache_clear = icache_clear_q;

endmodule
